// File: rtl/hb_session_ctrl.sv
// hb_session_ctrl: FIX session heartbeat/liveness scheduler driving one generator req/ack channel
// Ports: clk, rst (async active-low); enable_i session on; heartbeat_val_i HeartBtInt in ticks (0 = off);
//   tx_msg_sent_i / rx_msg_valid_i / rx_hb_match_i traffic pulses; gen_ack_i generator accept;
//   gen_req_o / gen_type_o (00 HB, 01 TestReq, 10 Logout) / testreq_id_o generator request;
//   session_timeout_o liveness-failure pulse; state_o debug state;
//   hb_sent_cnt_o / testreq_sent_cnt_o acked-message statistics, built only with HB_STATS_EN.
module hb_session_ctrl #(
  parameter int HB_RANGE = 16,
  parameter int TICK_DIV = 1000,
  parameter int GRACE    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [HB_RANGE-1:0] heartbeat_val_i,
  input  logic                tx_msg_sent_i,
  input  logic                rx_msg_valid_i,
  input  logic                rx_hb_match_i,
  input  logic                gen_ack_i,
  output logic                gen_req_o,
  output logic [1:0]          gen_type_o,
  output logic [7:0]          testreq_id_o,
  output logic                session_timeout_o,
  output logic [2:0]          state_o,
  output logic [15:0]         hb_sent_cnt_o,
  output logic [15:0]         testreq_sent_cnt_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ACTIVE = 3'd1, S_WAIT = 3'd2, S_LOGOUT = 3'd3, S_DONE = 3'd4;
  localparam logic [1:0] T_HB = 2'b00, T_TR = 2'b01, T_LO = 2'b10;
  localparam int PW = $clog2(TICK_DIV);
  logic [2:0]          r_state, w_next;
  logic [PW-1:0]       r_presc;
  logic [HB_RANGE:0]   r_tx_idle, r_rx_idle, w_tx_thr, w_rx_thr;
  logic [1:0]          r_type;
  logic [7:0]          r_id;
  logic                r_req, r_tr_pend, r_lo_pend;
  logic                w_tick, w_hb_en, w_live, w_tx_hit, w_rx_hit, w_match, w_tr_ev, w_lo_ev;
  logic                w_ack, w_hb_want, w_tr_want, w_lo_want, w_issue;
  assign w_hb_en   = |heartbeat_val_i;
  assign w_tx_thr  = {1'b0, heartbeat_val_i};
  assign w_rx_thr  = w_tx_thr + (HB_RANGE+1)'(GRACE);
  assign w_live    = (r_state == S_ACTIVE) || (r_state == S_WAIT);
  assign w_tick    = (r_state != S_IDLE) && (r_presc == PW'(TICK_DIV-1));
  assign w_tx_hit  = w_hb_en && (r_tx_idle >= w_tx_thr);
  // an inbound message in the threshold cycle proves liveness, so it masks the hit
  assign w_rx_hit  = w_hb_en && !rx_msg_valid_i && (r_rx_idle >= w_rx_thr);
  assign w_match   = rx_msg_valid_i && rx_hb_match_i;
  assign w_tr_ev   = enable_i && (r_state == S_ACTIVE) && w_rx_hit;
  assign w_lo_ev   = enable_i && (r_state == S_WAIT) && w_rx_hit;
  assign w_ack     = r_req && gen_ack_i;
  // the heartbeat request is the tx threshold level itself; any ack clears tx_idle and so drops it
  assign w_hb_want = w_live && w_tx_hit;
  assign w_tr_want = r_tr_pend || w_tr_ev;
  assign w_lo_want = r_lo_pend || w_lo_ev;
  assign w_issue   = !r_req && (w_hb_want || w_tr_want || w_lo_want);
  assign w_next = !enable_i              ? S_IDLE :
                  (r_state == S_IDLE)    ? S_ACTIVE :
                  (r_state == S_ACTIVE)  ? (w_tr_ev ? S_WAIT : S_ACTIVE) :
                  (r_state == S_WAIT)    ? (w_match ? S_ACTIVE : w_lo_ev ? S_LOGOUT : S_WAIT) :
                  (r_state == S_LOGOUT)  ? ((w_ack && r_type == T_LO) ? S_DONE : S_LOGOUT) :
                  S_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_tx_idle <= '0;
      r_rx_idle <= '0;
      r_req     <= 1'b0;
      r_type    <= T_HB;
      r_id      <= '0;
      r_tr_pend <= 1'b0;
      r_lo_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!enable_i || r_state == S_IDLE) begin
        r_presc   <= '0;
        r_tx_idle <= '0;
        r_rx_idle <= '0;
        r_req     <= 1'b0;
        r_tr_pend <= 1'b0;
        r_lo_pend <= 1'b0;
      end else begin
        r_presc   <= w_tick ? '0 : r_presc + 1'b1;
        r_tx_idle <= (!w_hb_en || tx_msg_sent_i || gen_ack_i) ? '0 :
                     (w_tick && !(&r_tx_idle)) ? r_tx_idle + 1'b1 : r_tx_idle;
        r_rx_idle <= (!w_hb_en || rx_msg_valid_i || w_tr_ev) ? '0 :
                     (w_tick && !(&r_rx_idle)) ? r_rx_idle + 1'b1 : r_rx_idle;
        r_req     <= w_issue || (r_req && !gen_ack_i);
        if (w_issue) r_type <= w_lo_want ? T_LO : w_tr_want ? T_TR : T_HB;
        // a queued Logout supersedes any TestRequest still waiting
        r_tr_pend <= w_tr_want && !w_lo_want && !w_issue;
        r_lo_pend <= w_lo_want && !w_issue;
        if (w_ack && r_type == T_TR) r_id <= r_id + 1'b1;
      end
    end
  assign gen_req_o         = r_req;
  assign gen_type_o        = r_type;
  assign testreq_id_o      = r_id;
  assign session_timeout_o = (r_state == S_DONE);
  assign state_o           = r_state;
`ifdef HB_STATS_EN
  logic [15:0] r_hb_cnt, r_tr_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hb_cnt <= '0;
      r_tr_cnt <= '0;
    end else if (w_ack && enable_i) begin
      if (r_type == T_HB && !(&r_hb_cnt)) r_hb_cnt <= r_hb_cnt + 1'b1;
      if (r_type == T_TR && !(&r_tr_cnt)) r_tr_cnt <= r_tr_cnt + 1'b1;
    end
  assign hb_sent_cnt_o      = r_hb_cnt;
  assign testreq_sent_cnt_o = r_tr_cnt;
`else
  assign hb_sent_cnt_o      = '0;
  assign testreq_sent_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hb_session_ctrl.sv
// tb_hb_session_ctrl: scoreboard bench for hb_session_ctrl (TICK_DIV=4, GRACE=1, HeartBtInt=3)
module tb_hb_session_ctrl;
  logic        clk = 1'b0, rst = 1'b0, enable_i = 1'b0, tx_msg_sent_i = 1'b0;
  logic        rx_msg_valid_i = 1'b0, rx_hb_match_i = 1'b0, gen_ack_i = 1'b0;
  logic [15:0] heartbeat_val_i = 16'd3;
  logic        gen_req_o, session_timeout_o;
  logic [1:0]  gen_type_o;
  logic [7:0]  testreq_id_o;
  logic [2:0]  state_o;
  logic [15:0] hb_sent_cnt_o, testreq_sent_cnt_o;
`ifdef HB_STATS_EN
  localparam int EXP_HB = 3;
`else
  localparam int EXP_HB = 0;
`endif
  int n_vec = 0, n_err = 0, cyc = 0, en_cyc = 0, req_cyc = 0, req_total = 0;
  int to_pulses = 0, wait_cnt = 0, ack_dly = 1, base;
  bit auto_ack = 1'b1, rx_auto = 1'b0;
  logic [9:0] sb_q[$];
  logic [9:0] held;
  hb_session_ctrl #(.HB_RANGE(16), .TICK_DIV(4), .GRACE(1)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .heartbeat_val_i(heartbeat_val_i),
    .tx_msg_sent_i(tx_msg_sent_i), .rx_msg_valid_i(rx_msg_valid_i), .rx_hb_match_i(rx_hb_match_i),
    .gen_ack_i(gen_ack_i), .gen_req_o(gen_req_o), .gen_type_o(gen_type_o),
    .testreq_id_o(testreq_id_o), .session_timeout_o(session_timeout_o), .state_o(state_o),
    .hb_sent_cnt_o(hb_sent_cnt_o), .testreq_sent_cnt_o(testreq_sent_cnt_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(negedge clk);
    rx_msg_valid_i = rx_auto && ((cyc - en_cyc) % 8 == 4);
    rx_hb_match_i  = 1'b0;
  endtask
  task automatic go_to(input int t);
    while (cyc < en_cyc + t) step();
  endtask
  task automatic push(input logic [1:0] t, input logic [7:0] id);
    sb_q.push_back({t, id});
  endtask
  task automatic start();
    en_cyc   = cyc;
    enable_i = 1'b1;
  endtask
  task automatic do_reset();
    enable_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
  endtask
  task automatic end_scn(input string tag);
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
    enable_i = 1'b0;
    rx_auto  = 1'b0;
    repeat (3) step();
    do_reset();
  endtask
  // generator model: acks after ack_dly cycles, checks stability and handshake, pops the scoreboard
  initial forever begin
    @(negedge clk);
    if (session_timeout_o) to_pulses++;
    if (gen_ack_i) begin
      chk("req_drop", 32'(gen_req_o), 0);
      gen_ack_i = 1'b0;
      wait_cnt  = 0;
    end else if (gen_req_o) begin
      wait_cnt++;
      if (wait_cnt == 1) begin
        held    = {gen_type_o, testreq_id_o};
        req_cyc = cyc;
        req_total++;
      end else chk("req_stable", 32'({gen_type_o, testreq_id_o}), 32'(held));
      if (auto_ack && wait_cnt > ack_dly) begin
        gen_ack_i = 1'b1;
        if (sb_q.size() == 0) chk("sb_unexpected", 32'({gen_type_o, testreq_id_o}), 32'h3FF);
        else chk("sb_txn", 32'({gen_type_o, testreq_id_o}), 32'(sb_q.pop_front()));
      end
    end else wait_cnt = 0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_req", 32'(gen_req_o), 0);
    chk("rst_type", 32'(gen_type_o), 0);
    chk("rst_id", 32'(testreq_id_o), 0);
    chk("rst_timeout", 32'(session_timeout_o), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_hbcnt", 32'(hb_sent_cnt_o), 0);
    chk("rst_trcnt", 32'(testreq_sent_cnt_o), 0);
    // heartbeats with periodic inbound traffic
    rx_auto = 1'b1;
    repeat (3) push(2'b00, 8'd0);
    start();
    go_to(15); chk("s1_hb1_lat", req_cyc - en_cyc, 14);
    go_to(27); chk("s1_hb2_lat", req_cyc - en_cyc, 26);
    go_to(39); chk("s1_hb3_lat", req_cyc - en_cyc, 38);
    go_to(42);
    chk("s1_state", 32'(state_o), 1);
    chk("s1_hbcnt", 32'(hb_sent_cnt_o), EXP_HB);
    chk("s1_trcnt", 32'(testreq_sent_cnt_o), 0);
    end_scn("s1_drain");
    // TestRequest answered, second TestRequest carries the next id
    push(2'b00, 8'd0); push(2'b01, 8'd0); push(2'b00, 8'd1); push(2'b01, 8'd1);
    start();
    go_to(18);
    chk("s2_wait", 32'(state_o), 2);
    chk("s2_tr_type", 32'(gen_type_o), 1);
    go_to(26);
    rx_msg_valid_i = 1'b1;
    rx_hb_match_i  = 1'b1;
    go_to(27); chk("s2_back_active", 32'(state_o), 1);
    go_to(46);
    chk("s2_hb_dropped", 32'(gen_req_o), 0);
    chk("s2_id", 32'(testreq_id_o), 2);
    end_scn("s2_drain");
    // no answer: Logout then one-cycle timeout pulse
    push(2'b00, 8'd0); push(2'b01, 8'd0); push(2'b00, 8'd1); push(2'b10, 8'd1);
    to_pulses = 0;
    start();
    go_to(34);
    chk("s3_logout_state", 32'(state_o), 3);
    chk("s3_logout_type", 32'(gen_type_o), 2);
    go_to(36);
    chk("s3_timeout_hi", 32'(session_timeout_o), 1);
    chk("s3_done_state", 32'(state_o), 4);
    go_to(37);
    chk("s3_timeout_lo", 32'(session_timeout_o), 0);
    chk("s3_idle_state", 32'(state_o), 0);
    enable_i = 1'b0;
    go_to(40); chk("s3_pulse_count", to_pulses, 1);
    end_scn("s3_drain");
    // delayed ack: request held stable, no duplicate
    ack_dly = 20;
    rx_auto = 1'b1;
    push(2'b00, 8'd0);
    start();
    go_to(24);
    chk("s4_req_held", 32'(gen_req_o), 1);
    chk("s4_type_held", 32'(gen_type_o), 0);
    go_to(40);
    chk("s4_no_dup", 32'(gen_req_o), 0);
    chk("s4_state", 32'(state_o), 1);
    end_scn("s4_drain");
    ack_dly = 1;
    // disable while a request is outstanding in WAIT_HB, then restart
    auto_ack = 1'b0;
    start();
    go_to(20);
    chk("s5_wait", 32'(state_o), 2);
    chk("s5_req_pending", 32'(gen_req_o), 1);
    enable_i = 1'b0;
    step();
    chk("s5_req_off", 32'(gen_req_o), 0);
    chk("s5_idle", 32'(state_o), 0);
    auto_ack = 1'b1;
    rx_auto  = 1'b1;
    push(2'b00, 8'd0);
    start();
    go_to(15); chk("s5_restart_lat", req_cyc - en_cyc, 14);
    go_to(18);
    end_scn("s5_drain");
    // heartbeat disabled
    heartbeat_val_i = 16'd0;
    base = req_total;
    start();
    go_to(100);
    chk("s6_no_req", req_total - base, 0);
    chk("s6_state", 32'(state_o), 1);
    chk("s6_req_low", 32'(gen_req_o), 0);
    heartbeat_val_i = 16'd3;
    end_scn("s6_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
